// File: rtl/pipe_out_fifo.sv
// pipe_out_fifo: first-word-fall-through elastic buffer placed after the
// pipeline stage. in_rdy comes from registered state only, so there is no
// combinational path from out_rdy to in_rdy.
// Optional feature: define PIPE_OUT_FIFO_STATS_EN to add the max_count
// high-water-mark output.
module pipe_out_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] in_val,
  input  logic             in_valid,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_val,
  output logic             out_valid,
  input  logic             out_rdy,
`ifdef PIPE_OUT_FIFO_STATS_EN
  output logic [CW-1:0]    max_count,
`endif
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             in_rdy_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_val_s;
  logic             push_s;
  logic             pop_s;

  // Advance a pointer; DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign push_s = in_valid & in_rdy_r;
  assign pop_s  = out_valid_r & out_rdy;

  // Occupancy update: +1 on push only, -1 on pop only, otherwise hold.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_val;
    end
  end

  // Pointers, occupancy and registered handshake flags.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_rdy_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r     <= count_next_s;
      in_rdy_r    <= (count_next_s < CW'(DEPTH));
      out_valid_r <= (count_next_s != {CW{1'b0}});
    end
  end

  // Head word is presented only while valid, zero otherwise.
  always_comb begin
    out_val_s = {WIDTH{1'b0}};
    if (out_valid_r) begin
      out_val_s = mem_r[rd_ptr_r];
    end else begin
      out_val_s = {WIDTH{1'b0}};
    end
  end

`ifdef PIPE_OUT_FIFO_STATS_EN
  logic [CW-1:0] max_count_r;

  // High-water mark; only reset clears it, saturates naturally at DEPTH.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      max_count_r <= {CW{1'b0}};
    end else if (count_next_s > max_count_r) begin
      max_count_r <= count_next_s;
    end else begin
      max_count_r <= max_count_r;
    end
  end

  assign max_count = max_count_r;
`endif

  assign in_rdy    = in_rdy_r;
  assign out_valid = out_valid_r;
  assign out_val   = out_val_s;
  assign count     = count_r;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Directed and table-driven bench for pipe_out_fifo (WIDTH=5, DEPTH=4).
module tb_pipe_out_fifo;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk_i;
  logic             reset_ni;
  logic [WIDTH-1:0] in_val;
  logic             in_valid;
  logic             in_rdy;
  logic [WIDTH-1:0] out_val;
  logic             out_valid;
  logic             out_rdy;
  logic [CW-1:0]    count;
`ifdef PIPE_OUT_FIFO_STATS_EN
  logic [CW-1:0]    max_count;
`endif

  int tests;
  int fails;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] val;
    logic             ordy;
    logic             e_rdy;
    logic             e_ov;
    logic [WIDTH-1:0] e_oval;
    logic [CW-1:0]    e_cnt;
  } vec_t;

  vec_t vecs [16];

  pipe_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .in_val    (in_val),
    .in_valid  (in_valid),
    .in_rdy    (in_rdy),
    .out_val   (out_val),
    .out_valid (out_valid),
    .out_rdy   (out_rdy),
`ifdef PIPE_OUT_FIFO_STATS_EN
    .max_count (max_count),
`endif
    .count     (count)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outs(input string tag, input int e_rdy, input int e_ov,
                            input int e_oval, input int e_cnt);
    check({tag, ".in_rdy"},    int'(in_rdy),    e_rdy);
    check({tag, ".out_valid"}, int'(out_valid), e_ov);
    check({tag, ".out_val"},   int'(out_val),   e_oval);
    check({tag, ".count"},     int'(count),     e_cnt);
  endtask

  initial begin
    int mcount;
    int q [$:15];
    logic iv;
    logic ordy;
    logic [WIDTH-1:0] v;
    logic push;
    logic pop;

    tests = 0;
    fails = 0;

    // iv, val, ordy | in_rdy, out_valid, out_val, count  (state after edge)
    vecs[0]  = '{1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 3'd1}; // push 3
    vecs[1]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0}; // pop 3
    vecs[2]  = '{1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 5'd1, 3'd1};
    vecs[3]  = '{1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 5'd1, 3'd2};
    vecs[4]  = '{1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 5'd1, 3'd3};
    vecs[5]  = '{1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 5'd1, 3'd4}; // full
    vecs[6]  = '{1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd1, 3'd4}; // 5 held upstream
    vecs[7]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd2, 3'd3}; // pop at full
    vecs[8]  = '{1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd3, 3'd3}; // push+pop
    vecs[9]  = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 3'd2};
    vecs[10] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 3'd1};
    vecs[11] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0};
    vecs[12] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0}; // empty pop ignored
    vecs[13] = '{1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 3'd1}; // push at empty
    vecs[14] = '{1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 3'd1}; // stall
    vecs[15] = '{1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0};

    // Reset state and first-edge in_rdy release.
    in_valid = 1'b0;
    in_val   = '0;
    out_rdy  = 1'b0;
    reset_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_outs("reset", 0, 0, 0, 0);
`ifdef PIPE_OUT_FIFO_STATS_EN
    check("reset.max_count", int'(max_count), 0);
`endif
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    check("release.in_rdy_before_edge", int'(in_rdy), 0);
    step();
    check_outs("release", 1, 0, 0, 0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].iv;
      in_val   = vecs[i].val;
      out_rdy  = vecs[i].ordy;
      step();
      check_outs($sformatf("vec%0d", i), int'(vecs[i].e_rdy), int'(vecs[i].e_ov),
                 int'(vecs[i].e_oval), int'(vecs[i].e_cnt));
    end

    // Random traffic against a reference queue.
    mcount = 0;
    for (int c = 0; c < 2000; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1) == 1;
      v    = WIDTH'($urandom_range(0, 31));
      in_valid = iv;
      in_val   = v;
      out_rdy  = ordy;
      push = iv && (mcount < DEPTH);
      pop  = ordy && (mcount > 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(int'(v));
      mcount = q.size();
      step();
      check_outs("rand", (mcount < DEPTH) ? 1 : 0, (mcount != 0) ? 1 : 0,
                 (mcount != 0) ? q[0] : 0, mcount);
    end
`ifdef PIPE_OUT_FIFO_STATS_EN
    check("rand.max_count", int'(max_count), DEPTH);
`endif

    // Drain, then reset mid-burst at count=3.
    in_valid = 1'b0;
    out_rdy  = 1'b1;
    repeat (5) step();
    check("drain.count", int'(count), 0);
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_val   = WIDTH'(21 + k);
      step();
    end
    in_valid = 1'b0;
    check_outs("burst", 1, 1, 21, 3);
    #2;
    reset_ni = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0);
`ifdef PIPE_OUT_FIFO_STATS_EN
    check("async_reset.max_count", int'(max_count), 0);
`endif
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();
    check_outs("post_reset", 1, 0, 0, 0);
    out_rdy  = 1'b0;
    in_valid = 1'b1;
    in_val   = 5'd7;
    step();
    in_valid = 1'b0;
    check_outs("post_reset_push", 1, 1, 7, 1);
    out_rdy = 1'b1;
    step();
    check_outs("post_reset_pop", 1, 0, 0, 0);
`ifdef PIPE_OUT_FIFO_STATS_EN
    check("post_reset.max_count", int'(max_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
